// File: rtl/sample_bist_pkg.sv
// sample_bist_pkg: shared types, widths and next-state helpers for the
// BIST controller of the `sample` block.
//   state_t    - controller states (DRAIN only reachable with
//                SAMPLE_BIST_RESP_REG_EN defined)
//   LFSR_W     - stimulus generator width (x^6+x^5+1, Fibonacci)
//   MISR_W     - signature width (x^8+x^4+x^3+x^2+1)
//   lfsr_next  - one LFSR step
//   misr_next  - one MISR compaction of a 3-bit response
package sample_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LFSR_W = 6;
    localparam int MISR_W = 8;
    localparam int RESP_W = 3;

    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    // Feedback taps of x^6+x^5+1: the two top state bits.
    localparam int LFSR_TAP_A = 5;
    localparam int LFSR_TAP_B = 4;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [RESP_W-1:0] d);
        logic [MISR_W-1:0] fb;
        fb = m[MISR_W-1] ? MISR_POLY : '0;
        return ({m[MISR_W-2:0], 1'b0} ^ fb) ^ {{(MISR_W-RESP_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/sample_bist_misr.sv
// sample_bist_misr: 8-bit multiple-input signature register.
//   clk, ret  - clock, synchronous active-high reset (clears signature)
//   clr       - clear to zero at the start of a run (wins over en)
//   en        - compact din this cycle
//   din[2:0]  - response {o,p,q}, o at bit 2
//   sig[7:0]  - current signature
module sample_bist_misr
    import sample_bist_pkg::*;
(
    input  logic              clk,
    input  logic              ret,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (ret || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule

// File: rtl/sample_bist.sv
// sample_bist: BIST controller for the `sample` combinational block.
// Drives a,b..f with an LFSR pattern stream for PATTERNS cycles, compacts
// {o,p,q} into an 8-bit MISR and compares the result against GOLDEN.
//   clk, ret        - clock, synchronous active-high reset
//   start           - one-cycle run request (honoured in IDLE and DONE only)
//   o, p, q         - responses from `sample`
//   a..f            - registered stimulus, {a..f} = LFSR state, 0 when idle
//   busy            - run in progress (RUN or DRAIN)
//   done            - run complete, pass/signature valid and stable
//   pass            - signature == GOLDEN, qualified by done
//   signature[7:0]  - MISR contents
// Build option: SAMPLE_BIST_RESP_REG_EN registers {o,p,q} before the MISR
// and adds a one-cycle DRAIN state; the final signature is unchanged.
module sample_bist
    import sample_bist_pkg::*;
#(
    parameter int          PATTERNS = 32,
    parameter logic [5:0]  SEED     = 6'h01,
    parameter logic [7:0]  GOLDEN   = 8'h00
) (
    input  logic       clk,
    input  logic       ret,
    input  logic       start,
    input  logic       o,
    input  logic       p,
    input  logic       q,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    localparam int CNT_W = $clog2(PATTERNS + 1);
    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PATTERNS - 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                last;
    logic                launch;
    logic                misr_en;
    logic [RESP_W-1:0]   misr_din;

    assign last   = (cnt_q == LAST);
    assign launch = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
`ifdef SAMPLE_BIST_RESP_REG_EN
            RUN:        if (last) state_d = DRAIN;
`else
            RUN:        if (last) state_d = DONE;
`endif
            DRAIN:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // The LFSR register is the pin register: loaded on launch, stepped in
    // RUN, and forced to 0 once the last vector has been applied.
    always_ff @(posedge clk) begin
        if (ret) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                lfsr_q <= SEED_EFF;
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                lfsr_q <= last ? '0 : lfsr_next(lfsr_q);
                cnt_q  <= cnt_q + CNT_W'(1);
            end else begin
                lfsr_q <= '0;
            end
        end
    end

`ifdef SAMPLE_BIST_RESP_REG_EN
    logic [RESP_W-1:0] resp_q;

    always_ff @(posedge clk) begin
        if (ret) resp_q <= '0;
        else     resp_q <= {o, p, q};
    end

    // resp_q lags one cycle: skip the first RUN cycle (it holds the idle
    // response) and pick up the final vector's response in DRAIN.
    assign misr_din = resp_q;
    assign misr_en  = (state_q == RUN && cnt_q != '0) || state_q == DRAIN;
`else
    assign misr_din = {o, p, q};
    assign misr_en  = (state_q == RUN);
`endif

    sample_bist_misr u_misr (
        .clk (clk),
        .ret (ret),
        .clr (launch),
        .en  (misr_en),
        .din (misr_din),
        .sig (signature)
    );

    assign {a, b, c, d, e, f} = lfsr_q;
    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);
    assign pass = done && (signature == GOLDEN);

endmodule

// File: tb/tb_sample_bist.sv
// tb_sample_bist: directed bench for sample_bist. A stand-in for `sample`
// (o = a|b|c|d, p = e|f, q = ~(e&f)) closes the loop on two instances:
//   u_dut  - PATTERNS=10, SEED=1, GOLDEN=5D (expected pass)
//   u_dut2 - PATTERNS=2,  SEED=0 (falls back to 1), GOLDEN=04 (expected fail)
// Expected vectors and signatures below are worked out by hand.
module tb_sample_bist;

`ifdef SAMPLE_BIST_RESP_REG_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif

    logic clk, ret, start, start2;
    logic o, p, q, a, b, c, d, e, f, busy, done, pass;
    logic o2, p2, q2, a2, b2, c2, d2, e2, f2, busy2, done2, pass2;
    logic [7:0] sig, sig2;
    logic [5:0] pins, pins2;

    int total = 0;
    int bad   = 0;

    assign pins  = {a, b, c, d, e, f};
    assign pins2 = {a2, b2, c2, d2, e2, f2};
    assign o  = |pins[5:2];
    assign p  = pins[1] | pins[0];
    assign q  = ~(pins[1] & pins[0]);
    assign o2 = |pins2[5:2];
    assign p2 = pins2[1] | pins2[0];
    assign q2 = ~(pins2[1] & pins2[0]);

    sample_bist #(.PATTERNS(10), .SEED(6'h01), .GOLDEN(8'h5D)) u_dut (
        .clk(clk), .ret(ret), .start(start), .o(o), .p(p), .q(q),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .busy(busy), .done(done), .pass(pass), .signature(sig)
    );

    sample_bist #(.PATTERNS(2), .SEED(6'h00), .GOLDEN(8'h04)) u_dut2 (
        .clk(clk), .ret(ret), .start(start2), .o(o2), .p(p2), .q(q2),
        .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR stream from seed 1 and MISR value after each compaction.
    logic [5:0] vec  [10] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10,
                              6'h21, 6'h03, 6'h06, 6'h0C, 6'h18};
    logic [7:0] sigs [10] = '{8'h03, 8'h05, 8'h0F, 8'h1B, 8'h33,
                              8'h61, 8'hC0, 8'h9A, 8'h2C, 8'h5D};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pins"}, 32'(pins), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_sig"},  32'(sig),  32'h0);
    endtask

    // Full run of u_dut from the cycle after the start edge; a stray start
    // pulse is injected at RUN cycle 3 and must change nothing.
    task automatic run_main(input string tag, input bit with_dut2);
        for (int k = 0; k < 10; k++) begin
            chk({tag, "_vec"},  32'(pins), 32'(vec[k]));
            chk({tag, "_busy"}, 32'(busy), 32'h1);
            chk({tag, "_done"}, 32'(done), 32'h0);
            chk({tag, "_sig"},  32'(sig),  (k - 1 - L >= 0) ? 32'(sigs[k-1-L]) : 32'h0);
            if (with_dut2) begin
                if (k < 2) chk("d2_vec", 32'(pins2), 32'(vec[k]));
                if (k == 2 && L == 1) chk("d2_drain_busy", 32'(busy2), 32'h1);
                if (k == 2 + L) begin
                    chk("d2_done", 32'(done2), 32'h1);
                    chk("d2_busy", 32'(busy2), 32'h0);
                    chk("d2_sig",  32'(sig2),  32'h05);
                    chk("d2_pass", 32'(pass2), 32'h0);
                    chk("d2_pins", 32'(pins2), 32'h0);
                end
            end
            if (k == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (L == 1) begin
            chk({tag, "_drain_busy"}, 32'(busy), 32'h1);
            chk({tag, "_drain_done"}, 32'(done), 32'h0);
            tick();
        end
        chk({tag, "_end_done"}, 32'(done), 32'h1);
        chk({tag, "_end_busy"}, 32'(busy), 32'h0);
        chk({tag, "_end_pins"}, 32'(pins), 32'h0);
        chk({tag, "_end_sig"},  32'(sig),  32'h5D);
        chk({tag, "_end_pass"}, 32'(pass), 32'h1);
    endtask

    initial begin
        ret = 1'b1; start = 1'b0; start2 = 1'b0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_d2_sig", 32'(sig2), 32'h0);
        ret = 1'b0;
        tick();
        chk_idle("idle");

        // First run, both instances launched together.
        start = 1'b1; start2 = 1'b1;
        tick();
        start = 1'b0; start2 = 1'b0;
        run_main("run1", 1'b1);

        // DONE holds its result.
        tick(); tick(); tick();
        chk("hold_done", 32'(done), 32'h1);
        chk("hold_sig",  32'(sig),  32'h5D);
        chk("hold_pass", 32'(pass), 32'h1);
        chk("hold_d2_sig", 32'(sig2), 32'h05);

        // Restart from DONE gives the same signature.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_main("run2", 1'b0);

        // Reset mid-run aborts with nothing retained.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_vec", 32'(pins), 32'(vec[3]));
        ret = 1'b1;
        tick();
        chk_idle("abort");
        ret = 1'b0;
        tick();
        tick();
        chk_idle("abort_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
